// File: rtl/catch_pkg.sv
// ---------------------------------------------------------------------------
// catch_pkg
// Shared definitions for the catch-game glove/ball datapath.
//   SUM_W / CNT_W    : coordinate-sum and hit-count accumulator widths
//   HC_W / VC_W      : camera column / row widths
//   SCREEN_W/H       : active camera frame size
//   DIV_IT_W         : width of the divider iteration counter
//   state_t          : glove tracker control states
//   on_screen()      : true when a pixel coordinate lies inside the frame
// ---------------------------------------------------------------------------
package catch_pkg;

   localparam int SUM_W    = 30;
   localparam int CNT_W    = 20;
   localparam int HC_W     = 11;
   localparam int VC_W     = 10;
   localparam int SCREEN_W = 1024;
   localparam int SCREEN_H = 768;
   localparam int DIV_IT_W = $clog2(SUM_W);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DIV_X = 2'd1,
      S_DIV_Y = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   function automatic logic on_screen(input logic [HC_W-1:0] h,
                                      input logic [VC_W-1:0] v);
      return (int'(h) < SCREEN_W) && (int'(v) < SCREEN_H);
   endfunction

endpackage

// File: rtl/glove_tracker_if.sv
// ---------------------------------------------------------------------------
// glove_tracker_if
// Bundle between the colour-classified pixel stream and the glove tracker.
//   Stream  : pix_valid, pix_hit, hcount, vcount, frame_end
//   Results : glove_x, glove_y, present, closed, valid, busy, overrun
// Modports:
//   master : pixel source / result consumer
//   slave  : the tracker
// ---------------------------------------------------------------------------
interface glove_tracker_if;
   import catch_pkg::*;

   logic            pix_valid;
   logic            pix_hit;
   logic [HC_W-1:0] hcount;
   logic [VC_W-1:0] vcount;
   logic            frame_end;
   logic [HC_W-1:0] glove_x;
   logic [VC_W-1:0] glove_y;
   logic            present;
   logic            closed;
   logic            valid;
   logic            busy;
   logic            overrun;

   modport master (
      output pix_valid, pix_hit, hcount, vcount, frame_end,
      input  glove_x, glove_y, present, closed, valid, busy, overrun
   );

   modport slave (
      input  pix_valid, pix_hit, hcount, vcount, frame_end,
      output glove_x, glove_y, present, closed, valid, busy, overrun
   );

endinterface

// File: rtl/serial_divider.sv
// ---------------------------------------------------------------------------
// serial_divider
// SUM_W-bit by CNT_W-bit restoring divider producing one quotient bit per
// clock. The first iteration is performed on the start edge, so o_done is
// high in the SUM_W-th cycle after the start edge.
// Ports:
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_start            : load operands (also restarts a running division)
//   i_dividend         : SUM_W-bit dividend
//   i_divisor          : CNT_W-bit divisor, must be non-zero
//   o_quot             : low Q_W bits of the quotient, held until next start
//   o_done             : one-cycle pulse when o_quot is complete
// ---------------------------------------------------------------------------
module serial_divider
   import catch_pkg::*;
#(
   parameter int Q_W = 11
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [SUM_W-1:0] i_dividend,
   input  logic [CNT_W-1:0] i_divisor,
   output logic [Q_W-1:0]   o_quot,
   output logic             o_done
);

   typedef struct packed {
      logic [CNT_W-1:0] rem;
      logic [SUM_W-1:0] q;   // dividend bits shift out the top, quotient bits in the bottom
   } div_st_t;

   // One restoring step. The remainder is always below the divisor, so the
   // shifted remainder fits CNT_W+1 bits and the subtraction's MSB is the borrow.
   function automatic div_st_t div_step(input div_st_t s, input logic [CNT_W-1:0] d);
      logic [CNT_W:0] sh;
      logic [CNT_W:0] diff;
      div_st_t        n;
      sh   = {s.rem, s.q[SUM_W-1]};
      diff = sh - {1'b0, d};
      n.q  = {s.q[SUM_W-2:0], ~diff[CNT_W]};
      n.rem = diff[CNT_W] ? sh[CNT_W-1:0] : diff[CNT_W-1:0];
      return n;
   endfunction

   div_st_t             r_st;
   logic [CNT_W-1:0]    r_div;
   logic [DIV_IT_W-1:0] r_it;
   logic                r_busy;
   logic                r_done;
   div_st_t             w_init;

   assign w_init = {{CNT_W{1'b0}}, i_dividend};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_it   <= '0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_busy <= 1'b1;
            r_it   <= DIV_IT_W'(1);
         end else if (r_busy) begin
            r_it <= r_it + 1'b1;
            if (r_it == DIV_IT_W'(SUM_W - 1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_start) begin
         r_st  <= div_step(w_init, i_divisor);
         r_div <= i_divisor;
      end else if (r_busy) begin
         r_st <= div_step(r_st, r_div);
      end
   end

   assign o_quot = r_st.q[Q_W-1:0];
   assign o_done = r_done;

endmodule

// File: rtl/glove_tracker.sv
// ---------------------------------------------------------------------------
// glove_tracker
// Per-frame centroid and grip detector for one coloured glove. Hit pixels
// are summed every cycle; on frame_end the totals are snapshotted and, if
// enough hits were seen, divided (x then y) by the hit count on a shared
// serial divider. The result is published with a one-cycle valid pulse.
// Ports:
//   vclock  : clock
//   reset   : synchronous active-high reset
//   io_bus  : glove_tracker_if.slave (pixel stream in, glove results out)
// Parameters:
//   MIN_PIXELS : hits needed for the glove to count as present
//   CLOSE_LO   : closed sets when the hit count is below this
//   CLOSE_HI   : closed clears when the hit count is above this
// ---------------------------------------------------------------------------
module glove_tracker
   import catch_pkg::*;
#(
   parameter int MIN_PIXELS = 16,
   parameter int CLOSE_LO   = 200,
   parameter int CLOSE_HI   = 400
) (
   input logic             vclock,
   input logic             reset,
   glove_tracker_if.slave  io_bus
);

   state_t           r_state;
   state_t           w_next;

   logic [SUM_W-1:0] r_sum_x;
   logic [SUM_W-1:0] r_sum_y;
   logic [CNT_W-1:0] r_cnt;
   logic [SUM_W-1:0] w_sum_x_fin;
   logic [SUM_W-1:0] w_sum_y_fin;
   logic [CNT_W-1:0] w_cnt_fin;
   logic             w_hit;

   logic [SUM_W-1:0] r_sum_y_snap;
   logic [CNT_W-1:0] r_cnt_snap;

   logic             w_accept;
   logic             w_enough;
   logic             w_busy;
   logic             w_overrun_set;
   logic             w_div_start;
   logic [SUM_W-1:0] w_dividend;
   logic [CNT_W-1:0] w_divisor;
   logic [HC_W-1:0]  w_quot;
   logic             w_div_done;

   logic [HC_W-1:0]  r_qx;
   logic [HC_W-1:0]  r_glove_x;
   logic [VC_W-1:0]  r_glove_y;
   logic             r_present;
   logic             r_closed;
   logic             r_valid;
   logic             r_overrun;

   // Totals including this cycle's pixel: the frame_end pixel belongs to
   // the frame it ends.
   assign w_hit       = io_bus.pix_valid & io_bus.pix_hit & on_screen(io_bus.hcount, io_bus.vcount);
   assign w_sum_x_fin = r_sum_x + (w_hit ? SUM_W'(io_bus.hcount) : '0);
   assign w_sum_y_fin = r_sum_y + (w_hit ? SUM_W'(io_bus.vcount) : '0);
   assign w_cnt_fin   = r_cnt + CNT_W'(w_hit);

   always_ff @(posedge vclock) begin
      if (reset || io_bus.frame_end) begin
         r_sum_x <= '0;
         r_sum_y <= '0;
         r_cnt   <= '0;
      end else begin
         r_sum_x <= w_sum_x_fin;
         r_sum_y <= w_sum_y_fin;
         r_cnt   <= w_cnt_fin;
      end
   end

   // A frame is only accepted when the divider is free; DONE counts as free
   // because its results are already captured.
   assign w_accept = io_bus.frame_end && (r_state == S_IDLE || r_state == S_DONE);
   assign w_enough = w_cnt_fin >= CNT_W'(MIN_PIXELS);

   always_ff @(posedge vclock) begin
      if (w_accept) begin
         r_sum_y_snap <= w_sum_y_fin;
         r_cnt_snap   <= w_cnt_fin;
      end
   end

   always_ff @(posedge vclock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (io_bus.frame_end) w_next = w_enough ? S_DIV_X : S_DONE;
         end
         S_DIV_X: begin
            if (w_div_done) w_next = S_DIV_Y;
         end
         S_DIV_Y: begin
            if (w_div_done) w_next = S_DONE;
         end
         S_DONE: begin
            if (io_bus.frame_end) w_next = w_enough ? S_DIV_X : S_DONE;
            else                  w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // x division starts straight from the live totals; y starts from the
   // snapshot on the same edge that x completes.
   always_comb begin
      w_busy        = (r_state == S_DIV_X) || (r_state == S_DIV_Y);
      w_overrun_set = io_bus.frame_end && w_busy;
      w_div_start   = (w_accept && w_enough) || (r_state == S_DIV_X && w_div_done);
      w_dividend    = w_sum_x_fin;
      w_divisor     = w_cnt_fin;
      if (r_state == S_DIV_X) begin
         w_dividend = r_sum_y_snap;
         w_divisor  = r_cnt_snap;
      end
   end

   serial_divider #(
      .Q_W (HC_W)
   ) u_div (
      .i_clk      (vclock),
      .i_rst      (reset),
      .i_start    (w_div_start),
      .i_dividend (w_dividend),
      .i_divisor  (w_divisor),
      .o_quot     (w_quot),
      .o_done     (w_div_done)
   );

   always_ff @(posedge vclock) begin
      if (reset) begin
         r_qx      <= '0;
         r_glove_x <= '0;
         r_glove_y <= '0;
         r_present <= 1'b0;
         r_closed  <= 1'b0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_valid   <= 1'b0;
         r_overrun <= w_overrun_set;
         if (r_state == S_DIV_X && w_div_done) r_qx <= w_quot;
         if (r_state == S_DONE) begin
            r_valid <= 1'b1;
            if (r_cnt_snap >= CNT_W'(MIN_PIXELS)) begin
               r_present <= 1'b1;
               r_glove_x <= r_qx;
               // y quotient is still held by the idle divider in DONE
               r_glove_y <= w_quot[VC_W-1:0];
               if (r_cnt_snap < CNT_W'(CLOSE_LO))      r_closed <= 1'b1;
               else if (r_cnt_snap > CNT_W'(CLOSE_HI)) r_closed <= 1'b0;
            end else begin
               r_present <= 1'b0;
            end
         end
      end
   end

   assign io_bus.glove_x = r_glove_x;
   assign io_bus.glove_y = r_glove_y;
   assign io_bus.present = r_present;
   assign io_bus.closed  = r_closed;
   assign io_bus.valid   = r_valid;
   assign io_bus.busy    = w_busy;
   assign io_bus.overrun = r_overrun;

endmodule

// File: tb/tb_glove_tracker.sv
// ---------------------------------------------------------------------------
// tb_glove_tracker
// Directed bench for glove_tracker: a table of rectangular hit frames with
// hand-computed centroids, plus hand-written sequences for frame_end in DONE,
// overrun and reset during a division.
// ---------------------------------------------------------------------------
module tb_glove_tracker;
   import catch_pkg::*;

   logic vclock = 1'b0;
   logic reset  = 1'b1;

   glove_tracker_if bus ();

   glove_tracker #(
      .MIN_PIXELS (16),
      .CLOSE_LO   (200),
      .CLOSE_HI   (400)
   ) dut (
      .vclock (vclock),
      .reset  (reset),
      .io_bus (bus)
   );

   always #5 vclock = ~vclock;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int x0, y0, w, h;
      int ex, ey, ep, ec;
   } vec_t;

   vec_t tbl[9];

   int lat, bsy, ovr, ox, oy, op, oc;
   int v_n, lat1, lat2, x1, y1, x2, y2, p2, ovr_n, ovr_k;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge vclock);
      #1;
   endtask

   task automatic drive(input bit v, input bit hit, input int h, input int vc, input bit fe);
      bus.pix_valid = v;
      bus.pix_hit   = hit;
      bus.hcount    = HC_W'(h);
      bus.vcount    = VC_W'(vc);
      bus.frame_end = fe;
   endtask

   task automatic idle_inputs();
      drive(1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   // Drives a w x h block of hits with decoy pixels before each row; returns
   // with frame_end driven on the last hit (that cycle is cycle 0).
   task automatic run_rect(input int x0, input int y0, input int w, input int h);
      for (int r = 0; r < h; r++) begin
         drive(1'b1, 1'b0, 1000, 700, 1'b0);
         step();
         drive(1'b0, 1'b1, 1000, 700, 1'b0);
         step();
         for (int c = 0; c < w; c++) begin
            drive(1'b1, 1'b1, x0 + c, y0 + r, (r == h - 1) && (c == w - 1));
            if (!((r == h - 1) && (c == w - 1))) step();
         end
      end
   endtask

   task automatic wait_valid(output int l, output int b, output int o,
                             output int x, output int y, output int p, output int c);
      l = -1; b = 0; o = 0; x = 0; y = 0; p = 0; c = 0;
      for (int k = 1; k <= 200; k++) begin
         step();
         idle_inputs();
         @(negedge vclock);
         if (bus.busy)    b++;
         if (bus.overrun) o++;
         if (bus.valid) begin
            l = k;
            x = int'(bus.glove_x);
            y = int'(bus.glove_y);
            p = int'(bus.present);
            c = int'(bus.closed);
            break;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{x0:100, y0:200, w:10, h:10, ex:104, ey:204, ep:1, ec:1};
      tbl[1] = '{x0:50,  y0:60,  w:5,  h:1,  ex:104, ey:204, ep:0, ec:1};
      tbl[2] = '{x0:300, y0:100, w:25, h:20, ex:312, ey:109, ep:1, ec:0};
      tbl[3] = '{x0:10,  y0:20,  w:20, h:15, ex:19,  ey:27,  ep:1, ec:0};
      tbl[4] = '{x0:600, y0:500, w:15, h:10, ex:607, ey:504, ep:1, ec:1};
      tbl[5] = '{x0:0,   y0:0,   w:20, h:15, ex:9,   ey:7,   ep:1, ec:1};
      tbl[6] = '{x0:900, y0:700, w:25, h:18, ex:912, ey:708, ep:1, ec:0};
      tbl[7] = '{x0:0,   y0:5,   w:16, h:1,  ex:7,   ey:5,   ep:1, ec:1};
      tbl[8] = '{x0:0,   y0:5,   w:15, h:1,  ex:7,   ey:5,   ep:0, ec:1};

      idle_inputs();
      reset = 1'b1;
      repeat (3) @(posedge vclock);
      #1;
      reset = 1'b0;
      @(negedge vclock);
      check("rst_glove_x", int'(bus.glove_x), 0);
      check("rst_glove_y", int'(bus.glove_y), 0);
      check("rst_present", int'(bus.present), 0);
      check("rst_closed",  int'(bus.closed),  0);
      check("rst_valid",   int'(bus.valid),   0);
      check("rst_busy",    int'(bus.busy),    0);
      check("rst_overrun", int'(bus.overrun), 0);
      step();

      // Table of frames
      for (int i = 0; i < 9; i++) begin
         run_rect(tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h);
         wait_valid(lat, bsy, ovr, ox, oy, op, oc);
         check($sformatf("tbl%0d_latency", i), lat, tbl[i].ep ? 62 : 2);
         check($sformatf("tbl%0d_glove_x", i), ox, tbl[i].ex);
         check($sformatf("tbl%0d_glove_y", i), oy, tbl[i].ey);
         check($sformatf("tbl%0d_present", i), op, tbl[i].ep);
         check($sformatf("tbl%0d_closed", i), oc, tbl[i].ec);
         check($sformatf("tbl%0d_busy_cycles", i), bsy, tbl[i].ep ? 60 : 0);
         check($sformatf("tbl%0d_overrun", i), ovr, 0);
         step();
         @(negedge vclock);
         check($sformatf("tbl%0d_valid_pulse", i), int'(bus.valid), 0);
         step();
         repeat (3) step();
      end

      // frame_end on the DONE cycle is accepted; its 16 hits sit at the
      // corner pixel with the last one on the frame_end cycle itself.
      run_rect(40, 30, 10, 10);
      v_n = 0; lat1 = -1; lat2 = -1; x1 = 0; y1 = 0; x2 = 0; y2 = 0; p2 = 0; ovr_n = 0;
      for (int k = 1; k <= 140; k++) begin
         step();
         if (k >= 46 && k <= 61) drive(1'b1, 1'b1, 1023, 767, k == 61);
         else                    idle_inputs();
         @(negedge vclock);
         if (bus.overrun) ovr_n++;
         if (bus.valid) begin
            v_n++;
            if (v_n == 1) begin
               lat1 = k; x1 = int'(bus.glove_x); y1 = int'(bus.glove_y);
            end else begin
               lat2 = k; x2 = int'(bus.glove_x); y2 = int'(bus.glove_y); p2 = int'(bus.present);
            end
         end
      end
      check("done_fe_valid_count", v_n, 2);
      check("done_fe_lat1", lat1, 62);
      check("done_fe_x1", x1, 44);
      check("done_fe_y1", y1, 34);
      check("done_fe_lat2", lat2, 123);
      check("last_pix_x", x2, 1023);
      check("last_pix_y", y2, 767);
      check("last_pix_present", p2, 1);
      check("done_fe_overrun", ovr_n, 0);
      repeat (3) step();

      // Second frame_end during DIV_X
      run_rect(100, 200, 10, 10);
      v_n = 0; lat1 = -1; x1 = 0; y1 = 0; ovr_n = 0; ovr_k = -1;
      for (int k = 1; k <= 160; k++) begin
         step();
         if (k == 20) drive(1'b1, 1'b1, 5, 5, 1'b1);
         else         idle_inputs();
         @(negedge vclock);
         if (bus.overrun) begin
            ovr_n++;
            ovr_k = k;
         end
         if (bus.valid) begin
            v_n++;
            lat1 = k; x1 = int'(bus.glove_x); y1 = int'(bus.glove_y);
         end
      end
      check("ovr_pulse_count", ovr_n, 1);
      check("ovr_pulse_cycle", ovr_k, 21);
      check("ovr_valid_count", v_n, 1);
      check("ovr_valid_cycle", lat1, 62);
      check("ovr_glove_x", x1, 104);
      check("ovr_glove_y", y1, 204);
      repeat (3) step();

      // Reset in cycle 10 of a division
      run_rect(40, 30, 10, 10);
      for (int k = 1; k <= 11; k++) begin
         step();
         idle_inputs();
         reset = (k == 10);
         @(negedge vclock);
         if (k == 9) check("mid_busy_before_reset", int'(bus.busy), 1);
      end
      check("mid_rst_glove_x", int'(bus.glove_x), 0);
      check("mid_rst_glove_y", int'(bus.glove_y), 0);
      check("mid_rst_present", int'(bus.present), 0);
      check("mid_rst_closed",  int'(bus.closed),  0);
      check("mid_rst_busy",    int'(bus.busy),    0);
      step();
      wait_valid(lat, bsy, ovr, ox, oy, op, oc);
      check("mid_rst_no_valid", lat, -1);
      step();
      run_rect(100, 200, 10, 10);
      wait_valid(lat, bsy, ovr, ox, oy, op, oc);
      check("post_rst_latency", lat, 62);
      check("post_rst_glove_x", ox, 104);
      check("post_rst_glove_y", oy, 204);
      check("post_rst_present", op, 1);
      check("post_rst_closed",  oc, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/glove_tracker.md
# glove_tracker

Per-frame centroid and grip detector for one coloured glove. It consumes the camera pixel stream after colour classification and produces the glove's relative x/y position plus an open/closed flag. These outputs feed the catch game's `rel_glove*` and `glove*closed` inputs. One instance is built per glove.

## Interface

Parameters:
- `MIN_PIXELS`, default 16: minimum hit count for the glove to be considered present.
- `CLOSE_LO`, default 200: `closed` sets when the hit count is below this value.
- `CLOSE_HI`, default 400: `closed` clears when the hit count is above this value. Must be greater than `CLOSE_LO`.

Ports:
- `vclock` in 1: single clock for the block.
- `reset` in 1: synchronous, active-high reset.
- `pix_valid` in 1: the current `hcount`/`vcount` is an active camera pixel.
- `pix_hit` in 1: the classifier matched glove colour at this pixel.
- `hcount` in 11: pixel column, 0..1023.
- `vcount` in 10: pixel row, 0..767.
- `frame_end` in 1: one-cycle pulse on the last pixel of a frame.
- `glove_x` out 11: centroid column.
- `glove_y` out 10: centroid row.
- `present` out 1: the last frame had at least `MIN_PIXELS` hits.
- `closed` out 1: grip flag, with hysteresis.
- `valid` out 1: one-cycle pulse when outputs update.
- `busy` out 1: the divider is running.
- `overrun` out 1: one-cycle pulse when a frame result is dropped.

## Operation

Accumulation:
- On each cycle with `pix_valid & pix_hit`: `sum_x += hcount` (30 b), `sum_y += vcount` (30 b), `cnt += 1` (20 b). None of these can overflow for a 1024×768 frame.
- On a `frame_end` cycle, the pixel on that cycle is included in the totals. The totals are then snapshotted, and the accumulators restart from 0 on the next cycle.
- Accumulation never stalls and is independent of the divider.

State machine, states IDLE, DIV_X, DIV_Y, DONE:
- IDLE, `frame_end` with snapshot `cnt >= MIN_PIXELS`: go to DIV_X.
- IDLE, `frame_end` with snapshot `cnt < MIN_PIXELS`: go to DONE with `present_next = 0`.
- DIV_X: 30 iterations of a restoring division `sum_x / cnt`, then go to DIV_Y.
- DIV_Y: 30 iterations of `sum_y / cnt`, then go to DONE.
- DONE: register the outputs, pulse `valid`, go to IDLE.

Division and output rules:
- Quotients truncate (floor). `glove_x` takes quotient bits [10:0] and `glove_y` takes bits [9:0]; no upper bits can be set.
- When not present, `glove_x`, `glove_y` and `closed` hold their previous values. `present` drops to 0.
- When present, `closed` is computed as:
  - `cnt < CLOSE_LO` sets it to 1.
  - `cnt > CLOSE_HI` clears it to 0.
  - Otherwise it holds.

Boundary conditions:
- `frame_end` while `busy` (not IDLE): the snapshot is discarded and `overrun` pulses on the following cycle. The running division is unaffected.
- `frame_end` on the same cycle as the DONE→IDLE transition is accepted.
- `reset` mid-division: the division is aborted and the block returns to IDLE with reset output values on the next edge.
- Reset values: all outputs are 0. Accumulators and `cnt` are 0, and the state is IDLE.

## Timing

Take the `frame_end` cycle as cycle 0.
- Present case:
  - DIV_X runs in cycles 1–30.
  - DIV_Y runs in cycles 31–60.
  - DONE is cycle 61.
  - `valid` is high and the new outputs are visible in cycle 62.
- Not-present case: DONE is cycle 1, and `valid` and the outputs appear in cycle 2.
- `busy` is high exactly while the state is DIV_X or DIV_Y.
- `overrun` is registered and high for exactly one cycle.
- The frame blanking interval is far longer than 62 cycles, so overrun only occurs from a misbehaving source.

## Structure

- `catch_pkg` holds:
  - accumulator widths (`SUM_W = 30`, `CNT_W = 20`);
  - the state encoding (IDLE/DIV_X/DIV_Y/DONE);
  - screen-size constants shared with the coordinate and ball stages.
- Sub-module `serial_divider` implements a 30-bit by 20-bit restoring divider, one bit per cycle, with `start`/`done`. It is instantiated once and reused for x then y.

## Test plan

1. **Centroid of a block:** 10×10 hits at x 100..109, y 200..209, then `frame_end`. Expected: `valid` at cycle 62, `glove_x = 104`, `glove_y = 204`, `present = 1`, `closed = 1` (count 100 < 200).
2. **Empty frame:** `frame_end` after 5 hits. Expected: `valid` at cycle 2, `present = 0`, position and `closed` unchanged.
3. **Hysteresis:** consecutive frames with counts 500, 300, 150, 300, 450. Expected `closed` sequence: 0, 0, 1, 1, 0.
4. **Overrun:** a second `frame_end` at cycle 20 of a division. Expected: `overrun` pulses at cycle 21, the first frame's result still appears at cycle 62, and there is no second `valid`.
5. **Last pixel counted:** a single hit at (1023, 767) on the `frame_end` cycle plus 15 hits at (1023, 767) earlier. Expected: `glove_x = 1023`, `glove_y = 767`, `present = 1`.
6. **Reset mid-division:** `reset` at cycle 10. Expected: all outputs 0 and `busy = 0` next cycle, and no `valid`. A following frame is processed normally.
